// File: rtl/dma_rd_tag_sched_if.sv
// Handshake bundle for dma_rd_tag_sched: tag allocation, reorder-buffer fetch and in-order output.
// master = scheduler side, slave = request generator / reorder buffer / consumer side.
interface dma_rd_tag_sched_if #(
  parameter int TAG_NUM_LOG = 6,
  parameter int DMA_DATA_W  = 256
) ();
  logic                   alloc_req;
  logic                   alloc_gnt;
  logic [TAG_NUM_LOG-1:0] alloc_tag;

  logic                   fetch_ren;
  logic [TAG_NUM_LOG-1:0] fetch_tag;
  logic                   fetch_last;
  logic [DMA_DATA_W-1:0]  fetch_data;
  logic                   fetch_vld;

  logic                   out_vld;
  logic                   out_last;
  logic [TAG_NUM_LOG-1:0] out_tag;
  logic [DMA_DATA_W-1:0]  out_data;
  logic                   out_rdy;

  modport master (
    input  alloc_req,
    output alloc_gnt, alloc_tag,
    output fetch_ren, fetch_tag,
    input  fetch_last, fetch_data, fetch_vld,
    output out_vld, out_last, out_tag, out_data,
    input  out_rdy
  );

  modport slave (
    output alloc_req,
    input  alloc_gnt, alloc_tag,
    input  fetch_ren, fetch_tag,
    output fetch_last, fetch_data, fetch_vld,
    input  out_vld, out_last, out_tag, out_data,
    output out_rdy
  );
endinterface

// File: rtl/dma_rd_tag_sched.sv
// DMA read tag scheduler: ring-order tag allocation, in-order reorder-buffer drain, 4-entry output FIFO.
// Optional statistics counters are built when DMA_RD_TAG_SCHED_STAT_EN is defined.
module dma_rd_tag_sched #(
  parameter int TAG_NUM_LOG = 6,
  parameter int DMA_DATA_W  = 256
) (
  input  logic                   dma_clk,
  input  logic                   rst_n,
  dma_rd_tag_sched_if.master     bus,
  output logic [TAG_NUM_LOG:0]   outstanding,
  output logic                   idle,
  output logic                   err_unexp
`ifdef DMA_RD_TAG_SCHED_STAT_EN
  ,
  input  logic                   stat_clr,
  output logic [31:0]            stat_alloc_cnt,
  output logic [31:0]            stat_stall_cnt
`endif
);
  localparam int ENTRY_W = 1 + TAG_NUM_LOG + DMA_DATA_W;
  localparam logic [TAG_NUM_LOG:0] TAG_NUM_CNT = {1'b1, {TAG_NUM_LOG{1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_RELEASE} state_t;

  state_t                 state, state_nxt;
  logic [TAG_NUM_LOG-1:0] alloc_ptr, head_ptr;
  logic [TAG_NUM_LOG:0]   outstanding_nxt;
  logic                   grant, release_tag, fetch_ren_q;

  logic [ENTRY_W-1:0]     fifo_mem [4];
  logic [1:0]             fifo_wr, fifo_rd;
  logic [2:0]             fifo_cnt, fifo_cnt_nxt;
  logic                   push, pop;
  logic [3:0]             credit_use;
  logic                   head_last;
  logic [TAG_NUM_LOG-1:0] head_tag;
  logic [DMA_DATA_W-1:0]  head_data;

  // No bypass: a tag freed this cycle is only grantable once the count register drops.
  assign grant           = bus.alloc_req && (outstanding < TAG_NUM_CNT);
  assign release_tag     = (state == ST_RELEASE);
  assign outstanding_nxt = outstanding + {{TAG_NUM_LOG{1'b0}}, grant}
                                       - {{TAG_NUM_LOG{1'b0}}, release_tag};

  assign bus.alloc_gnt = grant;
  assign bus.alloc_tag = alloc_ptr;
  assign bus.fetch_tag = head_ptr;

  assign pop          = bus.out_vld && bus.out_rdy;
  assign push         = bus.fetch_vld && ((fifo_cnt != 3'd4) || pop);
  assign fifo_cnt_nxt = fifo_cnt + {2'b00, push} - {2'b00, pop};
  assign credit_use   = {1'b0, fifo_cnt} + {3'b000, fetch_ren_q};

  // Fetch only while the FIFO can absorb every beat already in flight.
  always_comb begin
    state_nxt     = state;
    bus.fetch_ren = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (outstanding != '0) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.fetch_vld && bus.fetch_last) state_nxt = ST_RELEASE;
        else                                 bus.fetch_ren = (credit_use < 4'd3);
      end
      ST_RELEASE: begin
        state_nxt = (outstanding_nxt != '0) ? ST_DRAIN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      alloc_ptr   <= '0;
      head_ptr    <= '0;
      outstanding <= '0;
      fetch_ren_q <= 1'b0;
      idle        <= 1'b0;
      err_unexp   <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      fetch_ren_q <= bus.fetch_ren;
      idle        <= (outstanding_nxt == '0) && (fifo_cnt_nxt == 3'd0);
      if (grant)       alloc_ptr <= alloc_ptr + 1'b1;
      if (release_tag) head_ptr  <= head_ptr + 1'b1;
      if (bus.fetch_vld && (state != ST_DRAIN)) err_unexp <= 1'b1;
    end
  end

  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else begin
      fifo_cnt <= fifo_cnt_nxt;
      if (push) fifo_wr <= fifo_wr + 2'd1;
      if (pop)  fifo_rd <= fifo_rd + 2'd1;
    end
  end

  // Storage needs no reset; the head fields are masked whenever the FIFO is empty.
  always_ff @(posedge dma_clk) begin
    if (push) fifo_mem[fifo_wr] <= {bus.fetch_last, head_ptr, bus.fetch_data};
  end

  assign {head_last, head_tag, head_data} = fifo_mem[fifo_rd];
  assign bus.out_vld  = (fifo_cnt != 3'd0);
  assign bus.out_last = bus.out_vld && head_last;
  assign bus.out_tag  = bus.out_vld ? head_tag  : '0;
  assign bus.out_data = bus.out_vld ? head_data : '0;

`ifdef DMA_RD_TAG_SCHED_STAT_EN
  always_ff @(posedge dma_clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_alloc_cnt <= '0;
      stat_stall_cnt <= '0;
    end else if (stat_clr) begin
      stat_alloc_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (grant)                         stat_alloc_cnt <= stat_alloc_cnt + 32'd1;
      if (bus.out_vld && !bus.out_rdy)   stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
